// File: rtl/fpu_arbiter.sv
// fpu_arbiter
//    Lets two requesters share one fpu. Arbitration is round-robin. The
//    arbiter latches the winning request's operands, runs the fpu handshake
//    (fpu_en / fpu_done) and sends the result back to that requester.
//    Opcodes that are not float operations are rejected without reaching the
//    fpu. Every fpu operation is bounded by a timeout. A timeout marks the fpu
//    as hung until the next reset, and every later request is then rejected.
//
// Ports
//    clk, reset              clock; asynchronous active-high reset
//    req[1:0]                level request per requester, held until ack
//    op1_i/op2_i/instr_i     operands and opcode of requester i (i = 0, 1)
//    ack[1:0]                one-cycle pulse: operands of requester i captured
//    rsp_valid[1:0]          one-cycle pulse: rsp_data/rsp_err belong to i
//    rsp_data, rsp_err       response word, and the error flag
//                            (illegal opcode, timeout or hung fpu)
//    fpu_hung                sticky timeout flag
//    fpu_en, fpu_op1/op2/instr, fpu_result, fpu_done
//                            interface to the shared fpu
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrate, latch the winner, pulse ack
// ISSUE | first fpu_en cycle; fpu_done is ignored (may be stale)
// WAIT  | fpu_en held; wait for fpu_done or for the timeout
// RESP  | fpu_en low; rsp_valid for the winner is registered

module fpu_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [15:0] op1_0,
   input  logic [15:0] op2_0,
   input  logic [4:0]  instr_0,
   input  logic [15:0] op1_1,
   input  logic [15:0] op2_1,
   input  logic [4:0]  instr_1,
   output logic [1:0]  ack,
   output logic [1:0]  rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic        fpu_hung,
   output logic        fpu_en,
   output logic [15:0] fpu_op1,
   output logic [15:0] fpu_op2,
   output logic [4:0]  fpu_instr,
   input  logic [15:0] fpu_result,
   input  logic        fpu_done
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   localparam logic [4:0] OP_FIRST = 5'h11;
   localparam logic [4:0] OP_LAST  = 5'h16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           last_grant;
   logic           cur_grant;
   logic           grant;
   logic [TW-1:0]  timer;
   logic [15:0]    sel_op1;
   logic [15:0]    sel_op2;
   logic [4:0]     sel_instr;
   logic           sel_legal;
   logic           issue_ok;

   // Round-robin: a lone requester always wins. When both request, the one
   // that did not win last time wins.
   always_comb begin
      grant = 1'b0;
      if (req == 2'b01) begin
         grant = 1'b0;
      end else if (req == 2'b10) begin
         grant = 1'b1;
      end else begin
         grant = ~last_grant;
      end
   end

   always_comb begin
      sel_op1   = grant ? op1_1   : op1_0;
      sel_op2   = grant ? op2_1   : op2_0;
      sel_instr = grant ? instr_1 : instr_0;
   end

   assign sel_legal = (sel_instr >= OP_FIRST) && (sel_instr <= OP_LAST);
   assign issue_ok  = sel_legal && !fpu_hung;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fpu_en    = 1'b0;
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               state_nxt = issue_ok ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            fpu_en    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            fpu_en = 1'b1;
            if (fpu_done || (timer == T_LAST)) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack        <= 2'b00;
         rsp_valid  <= 2'b00;
         rsp_data   <= 16'h0000;
         rsp_err    <= 1'b0;
         fpu_hung   <= 1'b0;
         fpu_op1    <= 16'h0000;
         fpu_op2    <= 16'h0000;
         fpu_instr  <= 5'h00;
         last_grant <= 1'b1;
         cur_grant  <= 1'b0;
         timer      <= '0;
      end else begin
         ack       <= 2'b00;
         rsp_valid <= 2'b00;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  ack        <= grant ? 2'b10 : 2'b01;
                  cur_grant  <= grant;
                  last_grant <= grant;
                  fpu_op1    <= sel_op1;
                  fpu_op2    <= sel_op2;
                  fpu_instr  <= sel_instr;
                  // A rejected op skips the fpu. Its error response is
                  // loaded here so that it is ready when RESP pulses.
                  if (!issue_ok) begin
                     rsp_err  <= 1'b1;
                     rsp_data <= 16'h0000;
                  end
               end
            end
            ISSUE: begin
               timer <= '0;
            end
            WAIT: begin
               if (fpu_done) begin
                  rsp_data <= fpu_result;
                  rsp_err  <= 1'b0;
               end else if (timer == T_LAST) begin
                  rsp_data <= 16'h0000;
                  rsp_err  <= 1'b1;
                  fpu_hung <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RESP: begin
               // The pulse is registered, so it appears in the cycle after
               // RESP. rsp_data/rsp_err already hold the final values.
               rsp_valid <= cur_grant ? 2'b10 : 2'b01;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
